// File: rtl/muldiv_iter_pkg.sv
// Shared opcodes, FSM encoding and opcode-class helpers for the iterative multiply/divide unit.
package muldiv_iter_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OPNULL   = 5'h00,
        OPMUL    = 5'h0C,
        OPMULH   = 5'h0D,
        OPMULHSU = 5'h0E,
        OPMULHU  = 5'h0F,
        OPDIV    = 5'h10,
        OPDIVU   = 5'h11,
        OPREM    = 5'h12,
        OPREMU   = 5'h13
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_mul(input logic [OP_W-1:0] op);
        return op inside {OPMUL, OPMULH, OPMULHSU, OPMULHU};
    endfunction

    function automatic logic op_is_div(input logic [OP_W-1:0] op);
        return op inside {OPDIV, OPDIVU, OPREM, OPREMU};
    endfunction

    function automatic logic op_a_signed(input logic [OP_W-1:0] op);
        return op inside {OPMUL, OPMULH, OPMULHSU, OPDIV, OPREM};
    endfunction

    function automatic logic op_b_signed(input logic [OP_W-1:0] op);
        return op inside {OPMUL, OPMULH, OPDIV, OPREM};
    endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/result handshake bundle between a requester (master) and the muldiv unit (slave).
interface muldiv_iter_if
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             iFlush;
    logic             iValid;
    logic             oReady;
    logic [OP_W-1:0]  iControl;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oResult;
    logic             oBusy;

    modport master (
        output iFlush, iValid, iControl, iA, iB, iReady,
        input  oReady, oValid, oResult, oBusy
    );

    modport slave (
        input  iFlush, iValid, iControl, iA, iB, iReady,
        output oReady, oValid, oResult, oBusy
    );
endinterface

// File: rtl/muldiv_iter_step.sv
// One combinational radix-2 iteration: shift-add multiply and restoring divide, both computed;
// the caller picks which result registers to update.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic [WIDTH-1:0]   quo_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   rem_o,
    output logic [WIDTH-1:0]   quo_o
);
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        addend  = prod_i[0] ? opnd_i : '0;
        sum     = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        prod_o  = {sum, prod_i[WIDTH-1:1]};

        // rem < divisor always holds, so a borrow out of bit WIDTH means the trial failed
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_i};
        rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
    end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: IDLE/BUSY/DONE sequencer, iteration counter, sign fix-up.
//   state | meaning
//   IDLE  | ready for a request
//   BUSY  | one radix-2 step per cycle, counter counts down to 1
//   DONE  | result held until consumed or flushed
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    muldiv_iter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OP_W-1:0]    ctrl_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   result_q;
    logic               qsgn_q;
    logic               rsgn_q;
    logic               valid_q;
    logic               ready_q;
    logic               busy_q;

    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;

    logic               accept;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               fast;
    logic [WIDTH-1:0]   fast_res;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_res;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .prod_i (prod_q),
        .opnd_i (opnd_q),
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .prod_o (prod_d),
        .rem_o  (rem_d),
        .quo_o  (quo_d)
    );

    always_comb begin
        accept = (state_q == ST_IDLE) && bus.iValid && !bus.iFlush;
        sign_a = op_a_signed(bus.iControl) & bus.iA[WIDTH-1];
        sign_b = op_b_signed(bus.iControl) & bus.iB[WIDTH-1];
        abs_a  = sign_a ? -bus.iA : bus.iA;
        abs_b  = sign_b ? -bus.iB : bus.iB;
    end

    // Cases resolved at accept time without iterating
    always_comb begin
        fast     = 1'b0;
        fast_res = '0;
        if (!(op_is_mul(bus.iControl) || op_is_div(bus.iControl))) begin
            fast = 1'b1;
        end else if (op_is_div(bus.iControl) && (bus.iB == '0)) begin
            fast     = 1'b1;
            fast_res = (bus.iControl inside {OPDIV, OPDIVU}) ? '1 : bus.iA;
        end else if ((bus.iControl inside {OPDIV, OPREM}) && (bus.iA == MOST_NEG) && (bus.iB == '1)) begin
            fast     = 1'b1;
            fast_res = (bus.iControl == OPDIV) ? bus.iA : '0;
        end
    end

    always_comb begin
        prod_fix = qsgn_q ? -prod_d : prod_d;
        quo_fix  = qsgn_q ? -quo_d : quo_d;
        rem_fix  = rsgn_q ? -rem_d : rem_d;
        fix_res  = '0;
        case (ctrl_q)
            OPMUL:                      fix_res = prod_fix[WIDTH-1:0];
            OPMULH, OPMULHU, OPMULHSU:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
            OPDIV, OPDIVU:              fix_res = quo_fix;
            OPREM, OPREMU:              fix_res = rem_fix;
            default:                    fix_res = '0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ctrl_q   <= OPNULL;
            opnd_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            qsgn_q   <= 1'b0;
            rsgn_q   <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ctrl_q  <= bus.iControl;
                        qsgn_q  <= sign_a ^ sign_b;
                        rsgn_q  <= sign_a;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (fast) begin
                            state_q  <= ST_DONE;
                            result_q <= fast_res;
                            valid_q  <= 1'b1;
                        end else begin
                            state_q <= ST_BUSY;
                            cnt_q   <= CNT_W'(WIDTH);
                            // multiplicand for multiply, divisor for divide
                            opnd_q  <= op_is_mul(bus.iControl) ? abs_a : abs_b;
                            prod_q  <= {{WIDTH{1'b0}}, abs_b};
                            quo_q   <= abs_a;
                            rem_q   <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.iFlush) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (op_is_mul(ctrl_q)) begin
                            prod_q <= prod_d;
                        end else begin
                            rem_q <= rem_d;
                            quo_q <= quo_d;
                        end
                        if (cnt_q == CNT_W'(1)) begin
                            state_q  <= ST_DONE;
                            result_q <= fix_res;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.iFlush || bus.iReady) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oReady  = ready_q;
    assign bus.oValid  = valid_q;
    assign bus.oResult = result_q;
    assign bus.oBusy   = busy_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at WIDTH=32 with hand-computed results and latencies.
module tb_muldiv_iter;
    import muldiv_iter_pkg::*;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_bad;

    muldiv_iter_if #(.WIDTH(32)) bus ();

    muldiv_iter #(.WIDTH(32)) dut (
        .iCLK  (clk),
        .iRSTn (rstn),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request, wait for the result and consume it; lat=1 means valid right after accept edge.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        while (!bus.oReady && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        bus.iValid = 1'b1; bus.iControl = op; bus.iA = a; bus.iB = b;
        @(posedge clk); #1;
        bus.iValid = 1'b0; bus.iA = $urandom; bus.iB = $urandom; bus.iControl = OPMUL;
        lat = 1;
        while (!bus.oValid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        res = bus.oResult;
        bus.iReady = 1'b1;
        @(posedge clk); #1;
        bus.iReady = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.oReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.oReady); end
        n_cmp++; if (bus.oValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.oValid); end
        n_cmp++; if (bus.oBusy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.oBusy); end
        n_cmp++; if (bus.oResult !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.oResult); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        logic [4:0]  ops  [26];
        logic [31:0] va   [26];
        logic [31:0] vb   [26];
        logic [31:0] vexp [26];
        int          vlat [26];
        logic [31:0] res;
        int          lat;
        ops = '{OPMUL, OPMULH, OPMULHU, OPMULHSU, OPMULH, OPMULHU, OPMULHSU, OPMULH,
                OPDIVU, OPREMU, OPDIV, OPREM, OPDIV, OPREM, OPDIVU, OPREMU,
                OPDIV, OPREM, OPDIV, OPREM, OPDIVU, OPREMU, OPDIV, OPREM, OPDIVU, 5'h1F};
        va  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h2,
                32'h1234, 32'h1234, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                32'h80000000, 32'd9};
        vb  = '{32'd7, 32'd7, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7,
                32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd10, 32'd10, 32'h0, 32'h0,
                32'hFFFFFFFF, 32'd3};
        vexp = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'h00000006, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 32'h00001234, 32'h80000000, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                 32'hFFFFFFFD, 32'h1, 32'h3, 32'hFFFFFFFF, 32'h19999999, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF9,
                 32'h0, 32'h0};
        vlat = '{33, 33, 33, 33, 33, 33, 33, 33,
                 1, 1, 1, 1, 33, 33, 33, 33,
                 33, 33, 33, 33, 33, 33, 1, 1,
                 33, 1};
        for (int i = 0; i < 26; i++) begin
            run_op(ops[i], va[i], vb[i], res, lat);
            n_cmp++;
            if (res !== vexp[i]) begin
                n_bad++;
                $display("FAIL arith[%0d] op=%h a=%h b=%h: result %h want %h", i, ops[i], va[i], vb[i], res, vexp[i]);
            end
            n_cmp++;
            if (lat !== vlat[i]) begin
                n_bad++;
                $display("FAIL arith_lat[%0d] op=%h: latency %0d want %0d", i, ops[i], lat, vlat[i]);
            end
        end
    endtask

    task automatic test_hold();
        int          lat;
        logic [31:0] res;
        bus.iValid = 1'b1; bus.iControl = OPDIVU; bus.iA = 32'd100; bus.iB = 32'd7;
        @(posedge clk); #1;
        bus.iControl = OPMUL; bus.iA = 32'd3; bus.iB = 32'd5;
        lat = 1;
        while (!bus.oValid && lat < 200) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL hold_lat: latency %0d want 33", lat); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (bus.oResult !== 32'd14 || bus.oValid !== 1'b1 || bus.oReady !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_stable[%0d]: result %h valid %b ready %b want 0000000e 1 0",
                         c, bus.oResult, bus.oValid, bus.oReady);
            end
        end
        bus.iReady = 1'b1;
        @(posedge clk); #1;
        bus.iReady = 1'b0;
        n_cmp++;
        if (bus.oReady !== 1'b1 || bus.oBusy !== 1'b0 || bus.oValid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_consume: ready %b busy %b valid %b want 1 0 0", bus.oReady, bus.oBusy, bus.oValid);
        end
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        n_cmp++; if (bus.oBusy !== 1'b1) begin n_bad++; $display("FAIL hold_next_accept: busy %b want 1", bus.oBusy); end
        lat = 1;
        while (!bus.oValid && lat < 200) begin @(posedge clk); #1; lat++; end
        res = bus.oResult;
        n_cmp++; if (res !== 32'd15) begin n_bad++; $display("FAIL hold_next_result: %h want 0000000f", res); end
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL hold_next_lat: latency %0d want 33", lat); end
        bus.iReady = 1'b1;
        @(posedge clk); #1;
        bus.iReady = 1'b0;
    endtask

    task automatic test_abort(input logic use_reset, input int busy_cycles);
        logic [31:0] res;
        int          lat;
        int          seen;
        bus.iValid = 1'b1; bus.iControl = OPMUL; bus.iA = 32'd1000; bus.iB = 32'd1000;
        @(posedge clk); #1;
        bus.iValid = 1'b0;
        repeat (busy_cycles - 1) begin @(posedge clk); #1; end
        if (use_reset) rstn = 1'b0; else bus.iFlush = 1'b1;
        @(posedge clk); #1;
        rstn = 1'b1; bus.iFlush = 1'b0;
        n_cmp++;
        if (bus.oReady !== 1'b1 || bus.oBusy !== 1'b0 || bus.oValid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle(rst=%0b): ready %b busy %b valid %b want 1 0 0",
                     use_reset, bus.oReady, bus.oBusy, bus.oValid);
        end
        if (use_reset) begin
            n_cmp++;
            if (bus.oResult !== 32'h0) begin n_bad++; $display("FAIL abort_rst_result: %h want 0", bus.oResult); end
        end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.oValid) seen++; end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_valid(rst=%0b): valid seen %0d want 0", use_reset, seen); end
        run_op(OPMUL, 32'd3, 32'd5, res, lat);
        n_cmp++; if (res !== 32'd15) begin n_bad++; $display("FAIL abort_then_mul: %h want 0000000f", res); end
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL abort_then_mul_lat: latency %0d want 33", lat); end
    endtask

    task automatic test_flush_idle();
        bus.iValid = 1'b1; bus.iFlush = 1'b1; bus.iControl = OPDIVU; bus.iA = 32'd9; bus.iB = 32'd0;
        @(posedge clk); #1;
        bus.iValid = 1'b0; bus.iFlush = 1'b0;
        n_cmp++;
        if (bus.oBusy !== 1'b0 || bus.oValid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idle_block: busy %b valid %b want 0 0", bus.oBusy, bus.oValid);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn = 1'b0;
        bus.iValid = 1'b0; bus.iFlush = 1'b0; bus.iReady = 1'b0;
        bus.iControl = OPNULL; bus.iA = '0; bus.iB = '0;
        test_reset();
        test_arith();
        test_hold();
        test_abort(1'b0, 10);
        test_abort(1'b1, 20);
        test_flush_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
